// File: rtl/bpf_predecode_pkg.sv
`default_nettype none
// =============================================================================
// Module      : bpf_predecode_pkg
// Description : Shared BPU prediction/update types, branch encodings and the
//               direct-branch offset decode used by the pre-decode checker.
// Revision    : 1.0 - initial release
// =============================================================================
package bpf_predecode_pkg;

    localparam int BPU_FETCH_WIDTH = 2;
    // Wide enough for the largest supported packet (8 slots).
    localparam int BPU_FSC_W       = 3;

    typedef enum logic [1:0] {
        BRANCH_INVALID = 2'd0,
        PC_RELATIVE    = 2'd1,
        ABSOLUTE       = 2'd2,
        INDIRECT       = 2'd3
    } branch_type_t;

    typedef struct packed {
        branch_type_t branch_type;
    } ex_info_t;

    typedef struct packed {
        ex_info_t ex;
    } decode_info_t;

    typedef struct packed {
        logic                 taken;
        logic [BPU_FSC_W-1:0] fsc;
        logic [31:0]          npc;
        logic [2:0]           lphr;
        logic [4:0]           lphr_index;
    } bpu_predict_t;

    typedef struct packed {
        logic [31:0]  pc;
        logic [31:0]  br_target;
        logic         br_taken;
        branch_type_t br_type;
        logic [2:0]   lphr;
        logic [4:0]   lphr_index;
        logic         btb_update;
        logic         lpht_update;
        logic         bht_update;
    } bpu_update_t;

    localparam logic [5:0] OP_B    = 6'b010100;
    localparam logic [5:0] OP_BL   = 6'b010101;
    localparam logic [5:0] OP_BEQ  = 6'b010110;
    localparam logic [5:0] OP_BGEU = 6'b011011;

    // Byte offset of a direct branch: offs26 for B/BL, offs16 for compares.
    function automatic logic [31:0] direct_offset(input logic [31:0] inst);
        logic [25:0] offs26;
        logic [15:0] offs16;
        offs26 = {inst[9:0], inst[25:10]};
        offs16 = inst[25:10];
        if (inst[31:26] == OP_B || inst[31:26] == OP_BL) begin
            direct_offset = {{4{offs26[25]}}, offs26, 2'b00};
        end else begin
            direct_offset = {{14{offs16[15]}}, offs16, 2'b00};
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/bpf_target_calc.sv
`default_nettype none
// =============================================================================
// Module      : bpf_target_calc
// Description : Per-slot combinational direct-branch detect and target adder.
// Revision    : 1.0 - initial release
// =============================================================================
module bpf_target_calc
    import bpf_predecode_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [31:0] inst_i,
    output logic        direct_o,
    output logic [31:0] target_o
);

    logic [5:0] opcode;
    logic       is_uncond;
    logic       is_cond;

    assign opcode    = inst_i[31:26];
    assign is_uncond = (opcode == OP_B) || (opcode == OP_BL);
    assign is_cond   = (opcode >= OP_BEQ) && (opcode <= OP_BGEU);
    assign direct_o  = is_uncond || is_cond;
    assign target_o  = pc_i + direct_offset(inst_i);

endmodule
`default_nettype wire

// File: rtl/bpf_predecode.sv
`default_nettype none
// =============================================================================
// Module      : bpf_predecode
// Description : Pre-decode check of predicted-taken packets; corrects false
//               predictions, redirects fetch and queues BPU training updates.
//               Define BPF_TARGET_CHECK_EN to add the direct-target check.
// Revision    : 1.0 - initial release
// =============================================================================
module bpf_predecode
    import bpf_predecode_pkg::*;
#(
    parameter int FETCH_WIDTH = BPU_FETCH_WIDTH,
    parameter int UPD_DEPTH   = 4,
    parameter int CNT_W       = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    input  logic [31:0]                  pc_i,
    input  logic [FETCH_WIDTH-1:0][31:0] inst_i,
    input  decode_info_t [FETCH_WIDTH-1:0] decode_i,
    input  bpu_predict_t                 predict_i,
    output logic                         valid_o,
    output bpu_predict_t                 predict_o,
    output logic                         redirect_o,
    output logic [31:0]                  redirect_pc_o,
    output logic                         update_valid_o,
    input  logic                         update_ready_i,
    output bpu_update_t                  update_o,
    output logic [CNT_W-1:0]             fix_cnt_o
);

    localparam int PKT_BYTES = FETCH_WIDTH * 4;
    localparam int PTR_W     = $clog2(UPD_DEPTH);

    logic [31:0]          pc_base;
    logic [31:0]          fall_pc;
    logic [BPU_FSC_W-1:0] slot;
    branch_type_t         sel_type;
    logic                 false_taken;
    logic                 wrong_tgt;
    logic [31:0]          sel_target;
    logic                 corr;
    bpu_predict_t         pred_fix;
    bpu_update_t          upd_entry;
    logic                 accept;
    logic                 push;
    logic                 pop;

    logic                 valid_q;
    bpu_predict_t         predict_q;
    logic                 redirect_q;
    logic [31:0]          redirect_pc_q;
    logic [CNT_W-1:0]     fix_cnt_q,  fix_cnt_d;
    logic [PTR_W-1:0]     wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q,   rd_ptr_d;
    logic [PTR_W:0]       count_q,    count_d;
    bpu_update_t          mem_q [UPD_DEPTH];

    assign pc_base = pc_i & ~32'(PKT_BYTES - 1);
    assign fall_pc = pc_base + 32'(PKT_BYTES);
    assign slot    = predict_i.fsc & BPU_FSC_W'(FETCH_WIDTH - 1);

    always_comb begin
        sel_type = BRANCH_INVALID;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (slot == BPU_FSC_W'(i)) begin
                sel_type = decode_i[i].ex.branch_type;
            end
        end
    end

    assign false_taken = predict_i.taken && (sel_type == BRANCH_INVALID);

`ifdef BPF_TARGET_CHECK_EN
    logic [FETCH_WIDTH-1:0]       slot_direct;
    logic [FETCH_WIDTH-1:0][31:0] slot_target;
    logic                         sel_direct;

    for (genvar g = 0; g < FETCH_WIDTH; g++) begin : g_tcalc
        bpf_target_calc u_calc (
            .pc_i     (pc_base + 32'(g * 4)),
            .inst_i   (inst_i[g]),
            .direct_o (slot_direct[g]),
            .target_o (slot_target[g])
        );
    end

    always_comb begin
        sel_direct = 1'b0;
        sel_target = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (slot == BPU_FSC_W'(i)) begin
                sel_direct = slot_direct[i];
                sel_target = slot_target[i];
            end
        end
    end

    assign wrong_tgt = predict_i.taken && sel_direct && (predict_i.npc != sel_target);
`else
    logic unused_inst;
    assign unused_inst = ^inst_i;
    assign sel_target  = '0;
    assign wrong_tgt   = 1'b0;
`endif

    // False-taken outranks wrong-target.
    always_comb begin
        corr                 = 1'b0;
        pred_fix             = predict_i;
        upd_entry            = '0;
        upd_entry.pc         = pc_i;
        upd_entry.br_type    = PC_RELATIVE;
        upd_entry.lphr       = predict_i.lphr;
        upd_entry.lphr_index = predict_i.lphr_index;
        if (false_taken) begin
            corr                  = 1'b1;
            pred_fix.npc          = fall_pc;
            pred_fix.taken        = 1'b0;
            upd_entry.br_target   = fall_pc;
            upd_entry.br_taken    = 1'b0;
            upd_entry.btb_update  = 1'b1;
            upd_entry.lpht_update = 1'b1;
            upd_entry.bht_update  = 1'b1;
        end else if (wrong_tgt) begin
            corr                  = 1'b1;
            pred_fix.npc          = sel_target;
            upd_entry.br_target   = sel_target;
            upd_entry.br_taken    = 1'b1;
            upd_entry.btb_update  = 1'b1;
        end
    end

    // The packet following a redirect is fetch's shadow and is squashed.
    assign ready_o = count_q < (PTR_W + 1)'(UPD_DEPTH);
    assign accept  = valid_i && ready_o && !flush_i && !redirect_q;
    assign push    = accept && corr;
    assign pop     = update_valid_o && update_ready_i;

    always_comb begin
        fix_cnt_d = fix_cnt_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (push && (fix_cnt_q != '1)) begin
            fix_cnt_d = fix_cnt_q + CNT_W'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q       <= 1'b0;
            predict_q     <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            fix_cnt_q     <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            valid_q    <= accept;
            redirect_q <= push;
            if (accept) begin
                predict_q <= pred_fix;
            end
            if (push) begin
                redirect_pc_q <= pred_fix.npc;
            end
            fix_cnt_q <= fix_cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= upd_entry;
        end
    end

    assign valid_o        = valid_q;
    assign predict_o      = predict_q;
    assign redirect_o     = redirect_q;
    assign redirect_pc_o  = redirect_pc_q;
    assign fix_cnt_o      = fix_cnt_q;
    assign update_valid_o = (count_q != '0);
    assign update_o       = update_valid_o ? mem_q[rd_ptr_q] : '0;

endmodule
`default_nettype wire
